// File: rtl/bs_engine.sv
// Binary search engine over an external ascending memory; exact-match or lower-bound mode.
// One probe costs an ISSUE cycle (register mid) and a COMPARE cycle (consume read data).
module bs_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] target,
  input  logic              mode,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W:0]   loc,
  output logic [ADDR_W:0]   probes
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] DEPTH = IDX_W'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, ISSUE, COMPARE, DONE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    lo;
  logic [IDX_W-1:0]    hi;
  logic [ADDR_W-1:0]   mid;
  logic [DATA_W-1:0]   tgt;
  logic                md;

  logic [IDX_W-1:0]    mid_c;
  logic [IDX_W-1:0]    mid_ext_c;
  logic [IDX_W-1:0]    mid_inc_c;
  logic [IDX_W-1:0]    nxt_lo_c;
  logic [IDX_W-1:0]    nxt_hi_c;
  logic                eq_c;
  logic                hit_c;

  // Midpoint via lo + half-width so the sum never exceeds the interval bound.
  assign mid_c     = lo + ((hi - lo) >> 1);
  assign mid_ext_c = {1'b0, mid};
  assign mid_inc_c = mid_ext_c + IDX_W'(1);
  assign eq_c      = (mem_rdata == tgt);
  assign hit_c     = !md && eq_c;
  assign mem_addr  = mid;

  // Interval update for the current probe.
  always_comb begin
    nxt_lo_c = lo;
    nxt_hi_c = hi;
    if (!md) begin
      if (!eq_c) begin
        if (tgt < mem_rdata) nxt_hi_c = mid_ext_c;
        else                 nxt_lo_c = mid_inc_c;
      end
    end else begin
      if (mem_rdata < tgt) nxt_lo_c = mid_inc_c;
      else                 nxt_hi_c = mid_ext_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      mid    <= '0;
      tgt    <= '0;
      md     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      loc    <= '0;
      probes <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lo     <= '0;
            hi     <= DEPTH;
            tgt    <= target;
            md     <= mode;
            found  <= 1'b0;
            loc    <= '0;
            probes <= '0;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          mid    <= ADDR_W'(mid_c);
          probes <= probes + IDX_W'(1);
          state  <= COMPARE;
        end
        COMPARE: begin
          lo <= nxt_lo_c;
          hi <= nxt_hi_c;
          if (md && eq_c) found <= 1'b1;
          if (hit_c) begin
            found <= 1'b1;
            loc   <= mid_ext_c;
            state <= DONE;
          end else if (nxt_lo_c >= nxt_hi_c) begin
            // Exact-match miss reports index 0; lower-bound reports the insertion point.
            loc   <= md ? nxt_lo_c : '0;
            state <= DONE;
          end else begin
            state <= ISSUE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bs_engine.sv
// Self-checking bench for bs_engine: directed cases plus random sorted memories
// checked against a counting/membership model of the sorted array.
module tb_bs_engine;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] target;
  logic              mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W:0]   loc;
  logic [ADDR_W:0]   probes;

  logic [DATA_W-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int r_found, r_loc, r_probes, r_lat;
  int addrs[$];

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  bs_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .target(target), .mode(mode),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .found(found), .loc(loc), .probes(probes)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_linear(input int scale, input int div);
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'((i * scale) / div);
  endtask

  task automatic load_random();
    int q[$];
    for (int i = 0; i < DEPTH; i++) q.push_back(int'($urandom_range(0, 255)));
    q.sort();
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(q[i]);
  endtask

  // Runs one search from IDLE; latency counted in edges after the accepting edge.
  task automatic do_search(input logic [DATA_W-1:0] t, input logic m, input bit glitch);
    int n;
    bit got;
    addrs.delete();
    @(negedge clk);
    start = 1'b1; target = t; mode = m;
    @(posedge clk); #1;
    start = 1'b0; target = DATA_W'($urandom); mode = 1'($urandom);
    n = 0; got = 1'b0;
    while (n < 200 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("busy_in_search", busy, 1);
      if ((n % 2 == 1) && !done) addrs.push_back(int'(mem_addr));
      if (glitch && n == 3) begin start = 1'b1; target = ~t; mode = ~m; end
      if (glitch && n == 4) start = 1'b0;
      if (done) got = 1'b1;
    end
    if (!got) chk("done_timeout", 0, 1);
    r_found = int'(found); r_loc = int'(loc); r_probes = int'(probes); r_lat = n;
    @(posedge clk); #1;
    chk("done_single_pulse", done, 0);
    chk("result_hold_loc", loc, r_loc);
  endtask

  // Reference: lower bound = number of elements below t; membership by scan.
  task automatic check_model(input logic [DATA_W-1:0] t, input logic m);
    int lt;
    bit ex;
    lt = 0; ex = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] < t) lt++;
      if (mem[i] == t) ex = 1'b1;
    end
    chk("found", r_found, ex);
    if (m) chk("loc_lower_bound", r_loc, lt);
    else if (ex) chk("loc_hit_value", (r_loc < DEPTH) ? mem[r_loc] : 9999, t);
    else chk("loc_miss", r_loc, 0);
    chk("latency", r_lat, 2 * r_probes + 1);
    chk("probe_range", (r_probes >= 1 && r_probes <= ADDR_W + 1), 1);
    chk("probe_trace_len", addrs.size(), r_probes);
  endtask

  initial begin
    int exp_addr[4];
    int hits[$];
    exp_addr[0] = 16; exp_addr[1] = 8; exp_addr[2] = 12; exp_addr[3] = 10;

    reset = 1'b1; start = 1'b0; target = '0; mode = 1'b0;
    load_linear(2, 1);
    #12;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_found", found, 0); chk("rst_loc", loc, 0);
    chk("rst_probes", probes, 0); chk("rst_addr", mem_addr, 0);
    @(negedge clk); reset = 1'b0;

    // Even-valued memory: exact hit with a known probe trace.
    do_search(8'd20, 1'b0, 1'b0);
    chk("t20_found", r_found, 1); chk("t20_loc", r_loc, 10);
    chk("t20_probes", r_probes, 4); chk("t20_lat", r_lat, 9);
    for (int i = 0; i < 4; i++) chk("t20_addr", (i < addrs.size()) ? addrs[i] : -1, exp_addr[i]);

    do_search(8'd21, 1'b0, 1'b0);
    chk("t21_m0_found", r_found, 0); chk("t21_m0_loc", r_loc, 0);
    check_model(8'd21, 1'b0);
    do_search(8'd21, 1'b1, 1'b0);
    chk("t21_m1_found", r_found, 0); chk("t21_m1_loc", r_loc, 11);
    do_search(8'd255, 1'b1, 1'b0);
    chk("t255_found", r_found, 0); chk("t255_loc", r_loc, 32);
    do_search(8'd0, 1'b1, 1'b0);
    chk("t0_found", r_found, 1); chk("t0_loc", r_loc, 0);

    // Start/target/mode toggled mid-search must not disturb the result.
    do_search(8'd20, 1'b0, 1'b1);
    chk("glitch_found", r_found, 1); chk("glitch_loc", r_loc, 10);
    chk("glitch_probes", r_probes, 4); chk("glitch_lat", r_lat, 9);

    // Duplicates: value v occupies indices 4v..4v+3.
    load_linear(1, 4);
    do_search(8'd3, 1'b1, 1'b0);
    chk("dup_m1_found", r_found, 1); chk("dup_m1_loc", r_loc, 12);
    do_search(8'd3, 1'b0, 1'b0);
    chk("dup_m0_found", r_found, 1);
    chk("dup_m0_range", (r_loc >= 12 && r_loc <= 15), 1);
    check_model(8'd3, 1'b0);

    // Reset during the second ISSUE cycle, then a clean rerun.
    load_linear(2, 1);
    @(negedge clk); start = 1'b1; target = 8'd20; mode = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1; #1;
    chk("midrst_busy", busy, 0);   chk("midrst_done", done, 0);
    chk("midrst_found", found, 0); chk("midrst_loc", loc, 0);
    chk("midrst_probes", probes, 0); chk("midrst_addr", mem_addr, 0);
    @(negedge clk); reset = 1'b0;
    do_search(8'd20, 1'b0, 1'b0);
    chk("rerun_found", r_found, 1); chk("rerun_loc", r_loc, 10);
    chk("rerun_probes", r_probes, 4); chk("rerun_lat", r_lat, 9);

    // Start held high: each search takes 9 cycles plus one IDLE cycle.
    @(negedge clk); start = 1'b1; target = 8'd20; mode = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        hits.push_back(n);
        chk("b2b_busy_at_done", busy, 0);
        chk("b2b_loc", loc, 10);
      end
    end
    start = 1'b0;
    chk("b2b_count", hits.size(), 4);
    for (int i = 0; i < 4; i++) chk("b2b_pos", (i < hits.size()) ? hits[i] : -1, 9 + 10 * i);
    repeat (12) @(posedge clk);
    #1;
    chk("b2b_idle", busy, 0);

    // Random sorted memories against the model.
    for (int k = 0; k < 30; k++) begin
      logic [DATA_W-1:0] t;
      logic m;
      load_random();
      t = ($urandom_range(0, 1) == 0) ? mem[$urandom_range(0, DEPTH - 1)] : DATA_W'($urandom_range(0, 255));
      m = 1'($urandom);
      do_search(t, m, 1'b0);
      check_model(t, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bs_engine.md
BS_ENGINE -- requirements
Module: bs_engine

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the element and target width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; searched depth DEPTH = 2^ADDR_W.
REQ-003 clk  in  1  SHALL be the only clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  in  1  SHALL request a search when sampled high in IDLE.
REQ-006 target  in  DATA_W  SHALL give the value to search for; it is captured on accepted start.
REQ-007 mode  in  1  SHALL select the search mode (0 = exact match, 1 = lower-bound); it is captured on accepted start.
REQ-008 mem_addr  out  ADDR_W  SHALL carry the read address to the external sorted (ascending) memory.
REQ-009 mem_rdata  in  DATA_W  SHALL carry read data, valid the cycle after mem_addr is presented.
REQ-010 busy  out  1  SHALL be high in every state except IDLE.
REQ-011 done  out  1  SHALL pulse high for exactly one cycle when a result is final.
REQ-012 found  out  1  SHALL indicate that target exists in memory.
REQ-013 loc  out  ADDR_W+1  SHALL give the result index.
REQ-014 probes  out  ADDR_W+1  SHALL give the number of memory reads used by the last search.

Function
REQ-015 Internal lo/hi SHALL be ADDR_W+1 bits wide and define a half-open interval [lo, hi); on accept, lo=0, hi=DEPTH, probes=0, found=0.
REQ-016 The FSM SHALL have states IDLE, ISSUE, COMPARE and DONE.
REQ-017 Transitions SHALL be: IDLE->ISSUE on start; ISSUE->COMPARE always; COMPARE->ISSUE or DONE; DONE->IDLE always.
REQ-018 In ISSUE, mid = lo + ((hi-lo)>>1) SHALL be computed without overflow, registered, and driven on mem_addr, and probes SHALL increment.
REQ-019 mem_addr SHALL stay stable through the following COMPARE cycle.
REQ-020 In COMPARE with mode 0: on equality, found=1, loc=mid and the next state is DONE; if target < mem_rdata, hi=mid; otherwise lo=mid+1.
REQ-021 In COMPARE with mode 1: if mem_rdata < target, lo=mid+1; otherwise hi=mid, and found is set if the values are equal.
REQ-022 In mode 1, loc SHALL be the final lo (the first index with value >= target); loc = DEPTH when every element is less than target.
REQ-023 After a COMPARE, the next state SHALL be DONE when the updated lo >= hi; in mode 0 this means not found, loc=0 and found=0.
REQ-024 Comparisons SHALL be unsigned over DATA_W bits.
REQ-025 done SHALL assert exactly 2*probes+1 cycles after the edge that accepted start.
REQ-026 start while busy SHALL be ignored; target and mode changes while busy SHALL have no effect.
REQ-027 found, loc and probes SHALL hold their values from DONE until the next accepted start, at which point they clear.
REQ-028 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-029 Searches in mode 0 SHALL need at most ADDR_W+1 probes.

Reset
REQ-030 reset SHALL force IDLE immediately, independent of clk, at any point including mid-search.
REQ-031 Reset values SHALL be: busy=0, done=0, found=0, loc=0, probes=0, mem_addr=0, and lo/hi/mid/target/mode all 0.
REQ-032 After reset deasserts, the first start sampled on a rising edge SHALL be accepted normally; no partial result SHALL survive reset.

Verification
REQ-033 ADDR_W=5, mem[i]=2*i, mode 0, target 20 -> probes at 16, 8, 12, 10; found=1, loc=10, probes=4; done 9 cycles after start.
REQ-034 Same memory, mode 0, target 21 -> found=0, loc=0, done pulses once; mode 1, target 21 -> found=0, loc=11.
REQ-035 mem[i]=i/4 (duplicates), mode 1, target 3 -> found=1, loc=12; mode 0 -> found=1, loc in 12..15 with mem[loc]=3.
REQ-036 mem[i]=2*i, mode 1: target 255 -> found=0, loc=32; target 0 -> found=1, loc=0.
REQ-037 Reset asserted during the 2nd ISSUE -> busy=0, all outputs 0 in the same cycle; restart with target 20 -> result identical to REQ-033.
REQ-038 start held high continuously -> back-to-back searches, each with one done pulse and one IDLE cycle between searches; start pulsed while busy -> no effect.
